// File: rtl/memory_arbiter_pkg.sv
// ============================================================================
// memory_arbiter_pkg
//   Shared types for the memory arbiter and its round-robin picker.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package memory_arbiter_pkg;

   localparam int REGSIZE = 32;

   typedef logic [REGSIZE-1:0] DEFAULT_TYPE;

   typedef enum logic {
      MEMORY_READ  = 1'b0,
      MEMORY_WRITE = 1'b1
   } MEMORY_FLAG_TYPE;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ACCESS  = 2'd1,
      ARB_RESPOND = 2'd2
   } ARB_STATE_TYPE;

endpackage

`default_nettype wire

// File: rtl/memory_arbiter_rr_pick.sv
// ============================================================================
// memory_arbiter_rr_pick
//   Combinational round-robin winner search, starting after last_grant_i.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module memory_arbiter_rr_pick #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_grant_i,
   input  logic [NUM_REQ-1:0] exclude_i,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               valid_o
);

   logic [NUM_REQ-1:0] eligible;
   int                 cand;
   logic [IDX_W-1:0]   cand_idx;

   // The requester right after the last grant is examined first, the last grant itself last.
   always_comb begin
      eligible    = req_i & ~exclude_i;
      grant_idx_o = '0;
      valid_o     = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand     = (int'(last_grant_i) + off) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!valid_o && eligible[cand_idx]) begin
            valid_o     = 1'b1;
            grant_idx_o = cand_idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// memory_arbiter
//   Round-robin sharing of the single-ported memory_unit, one access per grant.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   input  MEMORY_FLAG_TYPE req_rw_flag_i     [NUM_REQ],
   input  DEFAULT_TYPE     req_address_i     [NUM_REQ],
   input  DEFAULT_TYPE     req_write_value_i [NUM_REQ],
   output logic [NUM_REQ-1:0] done_o,
   output DEFAULT_TYPE     read_value_o,
   output logic            busy_o,
   output MEMORY_FLAG_TYPE mem_rw_flag_o,
   output DEFAULT_TYPE     mem_address_o,
   output DEFAULT_TYPE     mem_write_value_o,
   input  DEFAULT_TYPE     mem_read_value_i
);

   localparam int IDX_W = $clog2(NUM_REQ);

   ARB_STATE_TYPE      state_q, state_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   DEFAULT_TYPE        read_value_q, read_value_d;
   logic               busy_q, busy_d;
   MEMORY_FLAG_TYPE    mem_rw_q, mem_rw_d;
   DEFAULT_TYPE        mem_addr_q, mem_addr_d;
   DEFAULT_TYPE        mem_wdata_q, mem_wdata_d;

   logic [NUM_REQ-1:0] exclude;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

   // During RESPOND the just-served requester still shows its old req, so it must be skipped.
   assign exclude = (state_q == ARB_RESPOND) ? (NUM_REQ'(1) << grant_q) : '0;

   memory_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req_i        (req_i),
      .last_grant_i (last_grant_q),
      .exclude_i    (exclude),
      .grant_idx_o  (pick_idx),
      .valid_o      (pick_valid)
   );

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      done_d       = '0;
      read_value_d = read_value_q;
      mem_rw_d     = mem_rw_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      case (state_q)
         ARB_IDLE, ARB_RESPOND: begin
            if (pick_valid) begin
               grant_d     = pick_idx;
               mem_rw_d    = req_rw_flag_i[pick_idx];
               mem_addr_d  = req_address_i[pick_idx];
               mem_wdata_d = req_write_value_i[pick_idx];
               state_d     = ARB_ACCESS;
            end else begin
               state_d     = ARB_IDLE;
            end
         end
         ARB_ACCESS: begin
            read_value_d = mem_read_value_i;
            done_d       = NUM_REQ'(1) << grant_q;
            last_grant_d = grant_q;
            mem_rw_d     = MEMORY_READ;
            state_d      = ARB_RESPOND;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      busy_d = (state_d != ARB_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ARB_IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         done_q       <= '0;
         read_value_q <= '0;
         busy_q       <= 1'b0;
         mem_rw_q     <= MEMORY_READ;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         done_q       <= done_d;
         read_value_q <= read_value_d;
         busy_q       <= busy_d;
         mem_rw_q     <= mem_rw_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign done_o            = done_q;
   assign read_value_o      = read_value_q;
   assign busy_o            = busy_q;
   assign mem_rw_flag_o     = mem_rw_q;
   assign mem_address_o     = mem_addr_q;
   assign mem_write_value_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// tb_memory_arbiter
//   Directed and randomized checks of memory_arbiter against a memory model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_arbiter;
   import memory_arbiter_pkg::*;

   localparam int NUM_REQ = 2;

   logic               clk;
   logic               rst_n;
   logic [NUM_REQ-1:0] req;
   MEMORY_FLAG_TYPE    req_rw   [NUM_REQ];
   DEFAULT_TYPE        req_addr [NUM_REQ];
   DEFAULT_TYPE        req_wd   [NUM_REQ];
   logic [NUM_REQ-1:0] done;
   DEFAULT_TYPE        read_value;
   logic               busy;
   MEMORY_FLAG_TYPE    mem_rw;
   DEFAULT_TYPE        mem_addr;
   DEFAULT_TYPE        mem_wdata;
   DEFAULT_TYPE        mem_rdata;

   DEFAULT_TYPE        mem     [16];
   DEFAULT_TYPE        ref_mem [16];
   logic               mem_load;

   int n_checks;
   int n_fail;

   memory_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .req_i             (req),
      .req_rw_flag_i     (req_rw),
      .req_address_i     (req_addr),
      .req_write_value_i (req_wd),
      .done_o            (done),
      .read_value_o      (read_value),
      .busy_o            (busy),
      .mem_rw_flag_o     (mem_rw),
      .mem_address_o     (mem_addr),
      .mem_write_value_o (mem_wdata),
      .mem_read_value_i  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic DEFAULT_TYPE init_val(input int i);
      return 32'hA000_0000 + 32'(i);
   endfunction

   // Single-ported memory: combinational read, write committed at the clock edge.
   assign mem_rdata = mem[mem_addr[3:0]];
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      end else if (mem_rw == MEMORY_WRITE) begin
         mem[mem_addr[3:0]] <= mem_wdata;
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_done"},   32'(done),       32'd0);
      check_value({tag, "_rdata"},  read_value,      32'd0);
      check_value({tag, "_busy"},   32'(busy),       32'd0);
      check_value({tag, "_rw"},     32'(mem_rw),     32'(MEMORY_READ));
      check_value({tag, "_addr"},   mem_addr,        32'd0);
      check_value({tag, "_wdata"},  mem_wdata,       32'd0);
   endtask

   // Randomized-phase bookkeeping
   logic pending  [NUM_REQ];
   int   wait_cnt [NUM_REQ];
   int   writes_seen;
   int   n_done;
   int   last_done_cyc;
   bit   draining;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      req      = '0;
      mem_load = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) begin
         req_rw[r]   = MEMORY_READ;
         req_addr[r] = '0;
         req_wd[r]   = '0;
         pending[r]  = 1'b0;
         wait_cnt[r] = 0;
      end
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

      tick();
      mem_load = 1'b0;
      tick();
      check_reset_outputs("por");
      rst_n = 1'b1;
      tick();
      check_value("idle_busy", 32'(busy), 32'd0);

      // Write of 'h3C to address 5 by requester 0
      req_rw[0] = MEMORY_WRITE; req_addr[0] = 32'd5; req_wd[0] = 32'h3C; req[0] = 1'b1;
      tick();
      check_value("wr_flag",  32'(mem_rw), 32'(MEMORY_WRITE));
      check_value("wr_addr",  mem_addr,    32'd5);
      check_value("wr_busy",  32'(busy),   32'd1);
      check_value("wr_nodone", 32'(done),  32'd0);
      tick();
      req[0] = 1'b0;
      check_value("wr_done",  32'(done),   32'b01);
      check_value("wr_flag1", 32'(mem_rw), 32'(MEMORY_READ));
      check_value("wr_mem",   mem[5],      32'h3C);
      ref_mem[5] = 32'h3C;
      tick();
      check_value("wr_done0", 32'(done),   32'd0);
      check_value("wr_idle",  32'(busy),   32'd0);

      // Read-back of address 5 by requester 1
      req_rw[1] = MEMORY_READ; req_addr[1] = 32'd5; req[1] = 1'b1;
      tick();
      check_value("rb_flag",  32'(mem_rw), 32'(MEMORY_READ));
      check_value("rb_addr",  mem_addr,    32'd5);
      tick();
      req[1] = 1'b0;
      check_value("rb_done",  32'(done),   32'b10);
      check_value("rb_data",  read_value,  32'h3C);
      check_value("rb_flag2", 32'(mem_rw), 32'(MEMORY_READ));
      tick();
      check_value("rb_done0", 32'(done),   32'd0);

      // Both requesters held high: alternating grants, one access every two cycles
      req_rw[0] = MEMORY_READ; req_addr[0] = 32'd5;
      req_rw[1] = MEMORY_READ; req_addr[1] = 32'd5;
      req = '1;
      n_done = 0;
      last_done_cyc = 0;
      for (int c = 1; c <= 40 && n_done < 8; c++) begin
         tick();
         if (done != '0) begin
            check_value("fair_order", 32'(done), 32'(NUM_REQ'(1) << (n_done % 2)));
            check_value("fair_gap",   32'(c - last_done_cyc), 32'd2);
            check_value("fair_data",  read_value, 32'h3C);
            last_done_cyc = c;
            n_done++;
            if (n_done == 8) req = '0;
         end
      end
      check_value("fair_count", 32'(n_done), 32'd8);
      tick();
      check_value("fair_idle", 32'(busy), 32'd0);
      check_value("fair_done0", 32'(done), 32'd0);

      // Asynchronous reset during the ACCESS cycle of a write
      req_rw[0] = MEMORY_WRITE; req_addr[0] = 32'd7; req_wd[0] = 32'hFF; req[0] = 1'b1;
      tick();
      check_value("rst_acc_flag", 32'(mem_rw), 32'(MEMORY_WRITE));
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      req[0] = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         check_value("rst_nodone", 32'(done), 32'd0);
         tick();
      end
      check_value("rst_mem7", mem[7], init_val(7));

      // Request dropped after grant still completes exactly once
      req_rw[1] = MEMORY_READ; req_addr[1] = 32'd9; req[1] = 1'b1;
      tick();
      check_value("drop_addr", mem_addr, 32'd9);
      req[1] = 1'b0;
      n_done = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (done != '0) begin
            check_value("drop_done", 32'(done), 32'b10);
            check_value("drop_data", read_value, ref_mem[9]);
            n_done++;
         end
      end
      check_value("drop_count", 32'(n_done), 32'd1);
      check_value("drop_idle",  32'(busy),   32'd0);

      // Randomized traffic checked against a transaction-level memory model
      writes_seen = 0;
      draining    = 1'b0;
      for (int cyc = 0; cyc < 630; cyc++) begin
         if (cyc == 600) draining = 1'b1;
         if (draining && !pending[0] && !pending[1]) break;
         tick();
         if (mem_rw == MEMORY_WRITE) writes_seen++;
         if (done != '0) begin
            check_value("rnd_onehot", 32'($countones(done)), 32'd1);
            for (int r = 0; r < NUM_REQ; r++) begin
               if (done[r]) begin
                  check_value("rnd_pending", 32'(pending[r]), 32'd1);
                  check_value("rnd_rdata", read_value, ref_mem[req_addr[r][3:0]]);
                  check_value("rnd_wrcnt", 32'(writes_seen),
                              (req_rw[r] == MEMORY_WRITE) ? 32'd1 : 32'd0);
                  writes_seen = 0;
                  if (req_rw[r] == MEMORY_WRITE) begin
                     ref_mem[req_addr[r][3:0]] = req_wd[r];
                     check_value("rnd_mem", mem[req_addr[r][3:0]], req_wd[r]);
                  end
                  pending[r] = 1'b0;
                  req[r]     = 1'b0;
                  for (int o = 0; o < NUM_REQ; o++) begin
                     if (o != r && pending[o]) begin
                        wait_cnt[o]++;
                        check_value("rnd_wait", 32'(wait_cnt[o] <= NUM_REQ - 1), 32'd1);
                     end
                  end
               end
            end
         end
         if (!draining) begin
            for (int r = 0; r < NUM_REQ; r++) begin
               if (!pending[r] && $urandom_range(0, 2) == 0) begin
                  req_rw[r]   = ($urandom_range(0, 1) == 1) ? MEMORY_WRITE : MEMORY_READ;
                  req_addr[r] = 32'($urandom_range(0, 15));
                  req_wd[r]   = $urandom;
                  pending[r]  = 1'b1;
                  wait_cnt[r] = 0;
                  req[r]      = 1'b1;
               end
            end
         end
      end
      check_value("drain", 32'({pending[0], pending[1]}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
